// File: rtl/npu_spi_pkg.sv
// Shared types and sizing helpers for the NPU SPI command slave.
package npu_spi_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, ERROR} state_e;

  localparam int NPU_CMD_W  = 8;
  localparam int NPU_TILE_W = 3;
  localparam int NPU_OP_W   = 3;
  localparam int NPU_DATA_W = 8;

  function automatic int hdr_w(input int cw, input int tw, input int ow);
    return cw + 2 * tw + ow;
  endfunction

  // Header fields in shift order; op_code lands in the low bits.
  localparam int NPU_OP_LSB  = 0;
  localparam int NPU_TJ_LSB  = NPU_OP_LSB + NPU_OP_W;
  localparam int NPU_TI_LSB  = NPU_TJ_LSB + NPU_TILE_W;
  localparam int NPU_CMD_LSB = NPU_TI_LSB + NPU_TILE_W;

  typedef struct packed {
    logic [NPU_CMD_W-1:0]  cmd;
    logic [NPU_TILE_W-1:0] tile_i;
    logic [NPU_TILE_W-1:0] tile_j;
    logic [NPU_OP_W-1:0]   op;
    logic [NPU_DATA_W-1:0] data;
    logic                  first;
  } npu_cmd_t;

endpackage

// File: rtl/npu_sync_fifo.sv
// Shift-register FIFO: the head always lives in entry 0, so outputs come straight from flops.
module npu_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     din_i,
  input  logic ready_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  T             mem_q [DEPTH];
  T             mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d, wr_idx;
  logic          pop, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[0];
  assign pop     = !empty_o && ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push_i && (!full_o || pop);
  assign wr_idx  = count_q - CW'(pop);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (push_ok && wr_idx == CW'(i)) mem_d[i] = din_i;
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/npu_spi_cmd_slave.sv
// SPI mode-0 command slave: header + payload burst into a FIFO, readback words out on MISO.
module npu_spi_cmd_slave
  import npu_spi_pkg::*;
#(
  parameter int CMD_W     = NPU_CMD_W,
  parameter int TILE_W    = NPU_TILE_W,
  parameter int OP_W      = NPU_OP_W,
  parameter int DATA_W    = NPU_DATA_W,
  parameter int DEPTH     = 4,
  parameter int MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [TILE_W-1:0] out_tile_i,
  output logic [TILE_W-1:0] out_tile_j,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow
);

  localparam int HDR_W   = hdr_w(CMD_W, TILE_W, OP_W);
  localparam int SR_W    = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int BC_W    = $clog2(SR_W + 1);
  localparam int WC_W    = $clog2(MAX_WORDS + 1);
  localparam int OP_LSB  = 0;
  localparam int TJ_LSB  = OP_LSB + OP_W;
  localparam int TI_LSB  = TJ_LSB + TILE_W;
  localparam int CMD_LSB = TI_LSB + TILE_W;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TILE_W-1:0] tile_i;
    logic [TILE_W-1:0] tile_j;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
    logic              first;
  } entry_t;

  // [0],[1] synchronise; [2] is the delayed copy for edge detection.
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [WC_W-1:0]   word_q, word_d;
  logic [SR_W-2:0]   sr_q, sr_d;
  logic [SR_W-1:0]   sr_shift;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [DATA_W-1:0] msr_q, msr_d;
  logic              miso_q, miso_d;
  logic              done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic              push, clean_end, fifo_full, fifo_empty;
  entry_t            push_entry, head;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];
  assign sr_shift  = {sr_q, mosi_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= 3'b111;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      cs_q   <= {cs_q[1:0], cs_n};
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    word_d     = word_q;
    sr_d       = sr_q;
    hdr_d      = hdr_q;
    msr_d      = msr_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    push       = 1'b0;
    clean_end  = 1'b0;
    push_entry = '{cmd: hdr_q[CMD_LSB +: CMD_W], tile_i: hdr_q[TI_LSB +: TILE_W],
                   tile_j: hdr_q[TJ_LSB +: TILE_W], op: hdr_q[OP_LSB +: OP_W],
                   data: sr_shift[DATA_W-1:0], first: (word_q == '0)};
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = HEADER;
          bit_d   = '0;
          word_d  = '0;
        end
      end
      HEADER: begin
        if (sclk_rise) begin
          sr_d  = sr_shift[SR_W-2:0];
          bit_d = bit_q + BC_W'(1);
          if (bit_q == BC_W'(HDR_W - 1)) begin
            hdr_d   = sr_shift[HDR_W-1:0];
            bit_d   = '0;
            msr_d   = rd_data;
            state_d = (sr_shift[CMD_LSB +: CMD_W] == '0) ? ERROR : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (sclk_fall) begin
          miso_d = msr_q[DATA_W-1];
          msr_d  = {msr_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          sr_d  = sr_shift[SR_W-2:0];
          bit_d = bit_q + BC_W'(1);
          if (bit_q == BC_W'(DATA_W - 1)) begin
            bit_d = '0;
            msr_d = rd_data;
            if (word_q == WC_W'(MAX_WORDS)) begin
              state_d = ERROR;
            end else begin
              push   = 1'b1;
              word_d = word_q + WC_W'(1);
            end
          end
        end
      end
      ERROR: ;
      default: state_d = IDLE;
    endcase
    // Frame end is judged after any coincident word completion has been applied.
    clean_end = (state_d == PAYLOAD) && (bit_d == '0) && (word_d != '0);
    if (cs_rise && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = clean_end;
      err_d   = !clean_end;
    end
    if (state_d != PAYLOAD || cs_q[1]) miso_d = 1'b0;
    ovf_d = ovf_q | (push && fifo_full && !(out_valid && out_ready));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      sr_q    <= '0;
      hdr_q   <= '0;
      msr_q   <= '0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sr_q    <= sr_d;
      hdr_q   <= hdr_d;
      msr_q   <= msr_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  npu_sync_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_entry),
    .ready_i (out_ready),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_cmd    = head.cmd;
  assign out_tile_i = head.tile_i;
  assign out_tile_j = head.tile_j;
  assign out_op     = head.op;
  assign out_data   = head.data;
  assign out_first  = head.first;
  assign miso       = miso_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;

endmodule
